// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock divider with bypass, glitch-free switching and staged config
module clk_div_prog #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_hi,
  output logic             cfg_done,
  output logic             clk_out,
  output logic             tick,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_BYP  = 2'b10
  } state_e;

  localparam logic [DIV_W:0] CNT_ONE = {{DIV_W{1'b0}}, 1'b1};

  state_e           state_q;
  logic [DIV_W-1:0] d_act;
  logic [DIV_W-1:0] h_act;
  logic [DIV_W-1:0] pend_d;
  logic [DIV_W-1:0] pend_h;
  logic             pend_valid;
  logic [DIV_W:0]   cnt;
  logic             clk_div;
  logic             done_q;

  logic [DIV_W:0]   p_act;
  logic [DIV_W:0]   he_act;
  logic [DIV_W:0]   cnt_inc;
  logic             at_boundary;
  logic             apply;
  logic             accept;
  logic [DIV_W-1:0] d_next;

  // Effective high time: the requested H when it fits strictly inside the period, else half the period.
  function automatic logic [DIV_W:0] calc_he(input logic [DIV_W-1:0] d, input logic [DIV_W-1:0] h);
    logic [DIV_W:0] p;
    p = {1'b0, d} + CNT_ONE;
    if ((h != '0) && ({1'b0, h} < p)) begin
      return {1'b0, h};
    end
    return p >> 1;
  endfunction

  // Period and high time of the active configuration, plus the apply/accept decisions.
  always_comb begin
    p_act       = {1'b0, d_act} + CNT_ONE;
    he_act      = calc_he(d_act, h_act);
    cnt_inc     = cnt + CNT_ONE;
    at_boundary = (cnt == p_act);
    apply       = pend_valid && ((state_q != ST_RUN) || at_boundary);
    accept      = cfg_valid && !pend_valid;
    d_next      = apply ? pend_d : d_act;
  end

  // Main FSM: config staging, period counter and registered divided clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_STOP;
      d_act      <= '0;
      h_act      <= '0;
      pend_d     <= '0;
      pend_h     <= '0;
      pend_valid <= 1'b0;
      cnt        <= CNT_ONE;
      clk_div    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= apply;
      if (apply) begin
        d_act      <= pend_d;
        h_act      <= pend_h;
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_d     <= cfg_div;
        pend_h     <= cfg_hi;
        pend_valid <= 1'b1;
      end

      case (state_q)
        ST_STOP: begin
          cnt     <= CNT_ONE;
          clk_div <= 1'b0;
          if (en) begin
            if (d_next != '0) begin
              state_q <= ST_RUN;
              clk_div <= 1'b1;
            end else begin
              state_q <= ST_BYP;
            end
          end
        end
        ST_RUN: begin
          if (at_boundary) begin
            // clk_div is low here (He < P), so leaving RUN cannot cut a high phase short.
            cnt <= CNT_ONE;
            if (!en) begin
              state_q <= ST_STOP;
              clk_div <= 1'b0;
            end else if (d_next == '0) begin
              state_q <= ST_BYP;
              clk_div <= 1'b0;
            end else begin
              clk_div <= 1'b1;
            end
          end else begin
            cnt     <= cnt_inc;
            clk_div <= (cnt_inc <= he_act);
          end
        end
        ST_BYP: begin
          cnt     <= CNT_ONE;
          clk_div <= 1'b0;
          if (!en) begin
            state_q <= ST_STOP;
          end else if (d_next != '0) begin
            // Enter RUN with clk_div rising together with clk.
            state_q <= ST_RUN;
            clk_div <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_STOP;
          cnt     <= CNT_ONE;
          clk_div <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = !pend_valid;
  assign cfg_done  = done_q;
  assign state     = state_q;
  assign tick      = (state_q == ST_BYP) || ((state_q == ST_RUN) && (cnt == CNT_ONE));
  assign clk_out   = (state_q == ST_BYP) ? clk : ((state_q == ST_RUN) ? clk_div : 1'b0);

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - self-checking bench for clk_div_prog against a period-position reference model
module tb_clk_div_prog;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [DIV_W-1:0] cfg_hi = '0;
  logic             cfg_ready;
  logic             cfg_done;
  logic             clk_out;
  logic             tick;
  logic [1:0]       state;

  clk_div_prog #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_hi(cfg_hi), .cfg_done(cfg_done), .clk_out(clk_out),
    .tick(tick), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hi_cnt = 0;
  int tick_cnt = 0;

  // Reference model: mode 0 stop / 1 run / 2 bypass, position 0..P-1 within the period.
  int m_mode, m_d, m_h, m_pd, m_ph, m_pos;
  bit m_pend, m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hi_eff();
    int p;
    p = m_d + 1;
    if (m_h >= 1 && m_h < p) return m_h;
    return p / 2;
  endfunction

  function automatic bit exp_div();
    return (m_mode == 1) && (m_pos < hi_eff());
  endfunction

  task automatic model_reset();
    m_mode = 0; m_d = 0; m_h = 0; m_pd = 0; m_ph = 0; m_pos = 0;
    m_pend = 0; m_done = 0;
  endtask

  task automatic model_update();
    int  p_old;
    bit  last;
    bit  apply;
    p_old = m_d + 1;
    last  = (m_mode == 1) && (m_pos == p_old - 1);
    apply = m_pend && (m_mode != 1 || last);
    m_done = apply;
    if (apply) begin
      m_d = m_pd; m_h = m_ph; m_pend = 0;
    end else if (cfg_valid && !m_pend) begin
      m_pd = cfg_div; m_ph = cfg_hi; m_pend = 1;
    end
    case (m_mode)
      0: if (en) begin m_mode = (m_d != 0) ? 1 : 2; m_pos = 0; end
      1: begin
        if (last) begin
          m_pos = 0;
          if (!en) m_mode = 0;
          else if (m_d == 0) m_mode = 2;
        end else begin
          m_pos++;
        end
      end
      default: begin
        if (!en) m_mode = 0;
        else if (m_d != 0) begin m_mode = 1; m_pos = 0; end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("clk_out_high_phase", clk_out, (m_mode == 2) ? 1 : exp_div());
    if (clk_out === 1'b1) hi_cnt++;
    if (tick === 1'b1) tick_cnt++;
    @(negedge clk);
    chk("clk_out_low_phase", clk_out, exp_div());
    chk("tick", tick, (m_mode == 2) || (m_mode == 1 && m_pos == 0));
    chk("state", state, m_mode);
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("cfg_done", cfg_done, m_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_cfg(input int d, input int h);
    for (int i = 0; i < 600 && m_pend; i++) step();
    if (m_pend) chk("cfg_slot_timeout", 1, 0);
    cfg_valid = 1'b1;
    cfg_div   = DIV_W'(d);
    cfg_hi    = DIV_W'(h);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_state", state, 0);
    chk("rst_tick", tick, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cfg_done", cfg_done, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_clk_out", clk_out, 0);
    chk("reset_tick", tick, 0);
    chk("reset_cfg_ready", cfg_ready, 1);
    chk("reset_cfg_done", cfg_done, 0);
    rstn = 1'b1;
    run(3);
    chk("stays_stopped", state, 0);

    // D=3 H=0: 2 high, 2 low, tick every 4 cycles
    load_cfg(3, 0);
    run(2);
    en = 1'b1;
    hi_cnt = 0; tick_cnt = 0;
    run(8);
    chk("p4_high_cycles", hi_cnt, 4);
    chk("p4_ticks", tick_cnt, 2);

    // D=4 with H=1 then H=7 (clamped to floor(P/2))
    load_cfg(4, 1);
    run(12);
    load_cfg(4, 7);
    run(12);

    // Reload mid-period: current period finishes first
    load_cfg(3, 0);
    run(6);
    load_cfg(5, 0);
    run(16);

    // RUN -> BYP -> RUN
    load_cfg(2, 0);
    run(6);
    load_cfg(0, 0);
    run(6);
    chk("bypass_entered", state, 2);
    load_cfg(1, 0);
    run(4);
    chk("run_from_bypass", state, 1);
    run(4);

    // Drop en at the first cycle of a P=6 period
    load_cfg(5, 0);
    for (int i = 0; i < 40 && !(m_mode == 1 && m_pos == 0 && m_d == 5); i++) step();
    en = 1'b0;
    run(5);
    chk("period_completes", state, 1);
    step();
    chk("stopped_after_period", state, 0);
    chk("stopped_clk_out", clk_out, 0);
    chk("stopped_tick", tick, 0);

    // D=255: P=256, He=128, then asynchronous reset mid-period
    load_cfg(255, 0);
    run(2);
    en = 1'b1;
    hi_cnt = 0; tick_cnt = 0;
    run(256);
    chk("p256_high_cycles", hi_cnt, 128);
    chk("p256_ticks", tick_cnt, 1);
    run(30);
    async_reset();
    en = 1'b0;
    run(3);

    // Randomized traffic
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_div   = ($urandom_range(0, 15) == 0) ? DIV_W'($urandom_range(0, 255))
                                               : DIV_W'($urandom_range(0, 6));
      cfg_hi    = DIV_W'($urandom_range(0, 12));
      if ($urandom_range(0, 599) == 0) begin
        cfg_valid = 1'b0;
        async_reset();
      end
      step();
    end
    cfg_valid = 1'b0;
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter DIV_W, default 8, giving the width of the divisor and high-time fields.
REQ-002 SHALL have port clk, input, 1, source clock; all logic is on the posedge.
REQ-003 SHALL have port rstn, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port en, input, 1, run request for the divided clock.
REQ-005 SHALL have port cfg_valid, input, 1, new configuration offered.
REQ-006 SHALL have port cfg_ready, output, 1, configuration slot free.
REQ-007 SHALL have port cfg_div, input, DIV_W, divisor code D; period P = D+1 clk cycles; D=0 selects bypass.
REQ-008 SHALL have port cfg_hi, input, DIV_W, requested high-phase length H in clk cycles.
REQ-009 SHALL have port cfg_done, output, 1, one-cycle pulse when a pending configuration becomes active.
REQ-010 SHALL have port clk_out, output, 1, generated clock.
REQ-011 SHALL have port tick, output, 1, period-start strobe in the clk domain.
REQ-012 SHALL have port state, output, 2, current FSM state: 00 STOP, 01 RUN, 10 BYP.

Function
REQ-013 SHALL accept a configuration when cfg_valid && cfg_ready and hold it in a pending register; cfg_ready SHALL deassert the next cycle and reassert in the cycle cfg_done pulses.
REQ-014 SHALL apply pending config in STOP and BYP on the cycle after acceptance; in RUN only at the period boundary (cnt==P).
REQ-015 SHALL compute P = {1'b0,D}+1 in DIV_W+1 bits, so D=2^DIV_W-1 gives P=2^DIV_W with no overflow.
REQ-016 SHALL use effective high time He = H when 1<=H<P, else floor(P/2).
REQ-017 SHALL run counter cnt 1..P in RUN, incrementing each clk and wrapping P->1; cnt SHALL hold at 1 outside RUN.
REQ-018 SHALL register clk_div as 1 for cycles where cnt is 1..He and 0 where cnt is He+1..P, giving a duty of exactly He/P.
REQ-019 SHALL drive clk_out = clk_div in RUN, clk in BYP, and 0 in STOP.
REQ-020 SHALL assert tick for one cycle when cnt==1 in RUN; in BYP tick SHALL be 1 every cycle; in STOP 0.
REQ-021 STOP transitions: en && D_active!=0 -> RUN with cnt=1 and clk_div=1; en && D_active==0 -> BYP.
REQ-022 RUN transitions, evaluated only at cnt==P after any pending apply: !en -> STOP; new D==0 -> BYP; else stay in RUN with cnt=1.
REQ-023 SHALL never end a divided period early: en deassertion mid-period completes the current period first.
REQ-024 BYP transitions: !en -> STOP next cycle; applied D!=0 -> RUN with cnt=1 and clk_div=1.
REQ-025 Simultaneous boundary, config apply and en=0 SHALL apply the config, pulse cfg_done, then enter STOP.
REQ-026 Each switch into or out of BYP from RUN SHALL occur on a posedge while clk_div=0 or clk_div is rising, so no runt pulse is produced.

Reset
REQ-027 On rstn low the block SHALL enter STOP with D_active=0, H_active=0, pending empty, cnt=1, clk_div=0, clk_out=0, tick=0, cfg_done=0 and cfg_ready=1.
REQ-028 Reset SHALL take effect immediately on assertion, abandoning any period mid-way, and discard any pending configuration.
REQ-029 After rstn deasserts the block SHALL stay in STOP until en is sampled high.

Verification
REQ-030 Load D=3, H=0, then set en=1 -> RUN; clk_out is 2 cycles high, 2 cycles low, repeating; tick fires every 4 cycles.
REQ-031 D=4, H=1 -> P=5; clk_out is 1 cycle high, 4 low. Then H=7 (7>=P) -> He=2, giving 2 high, 3 low.
REQ-032 Running at D=3, load D=5 at cnt=2 -> cfg_ready=0; the current 4-cycle period completes, cfg_done pulses, and the next period is 6 cycles (3 high).
REQ-033 Running at D=2, load D=0 -> at the boundary state goes to BYP and clk_out follows clk; load D=1 -> RUN with P=2.
REQ-034 Drop en at cnt=1 of a P=6 period -> 5 more cycles run, then STOP; clk_out=0 and tick=0.
REQ-035 D=255 with DIV_W=8 -> P=256 and He=128. Assert rstn low mid-period -> clk_out=0 and state=00 immediately.
